// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 app-interface requester.
package ddr3_app_pkg;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        CALIB = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/ddr3_rsp_fifo.sv
// Synchronous read-response FIFO; head entry is always presented on rd_data.
module ddr3_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  do_rd;

    assign do_rd = rd_en && !empty;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage array; a push while full overwrites the slot being popped that cycle.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ddr3_app_requester.sv
// Single-beat read/write initiator for the MIG 7-series app interface.
module ddr3_app_requester
    import ddr3_app_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned RSP_DEPTH  = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      init_calib_complete,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_data,
    input  logic [DATA_WIDTH/8-1:0]   req_mask,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    input  logic                      app_rdy,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [DATA_WIDTH-1:0]     app_wdf_data,
    output logic [DATA_WIDTH/8-1:0]   app_wdf_mask,
    input  logic                      app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]     app_rd_data,
    input  logic                      app_rd_data_valid,
    output logic [$clog2(RSP_DEPTH):0] reads_outstanding
);

    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = $clog2(RSP_DEPTH) + 1;

    state_t                 state_q, state_d;
    logic                   app_en_d;
    logic [2:0]             app_cmd_d;
    logic [ADDR_WIDTH-1:0]  app_addr_d;
    logic                   wren_d;
    logic [DATA_WIDTH-1:0]  wdata_d;
    logic [MASK_WIDTH-1:0]  wmask_d;
    logic [CNT_WIDTH-1:0]   credits_q, credits_d;
    logic                   req_fire;
    logic                   rd_fire;
    logic                   rsp_pop;
    logic                   rsp_full;
    logic                   rsp_empty;

    // Reads need a free response slot; writes only need the FSM to be idle.
    assign req_ready = (state_q == IDLE) && init_calib_complete &&
                       (req_write || (credits_q != CNT_WIDTH'(RSP_DEPTH)));
    assign req_fire  = req_valid && req_ready;
    assign rd_fire   = req_fire && !req_write;
    assign rsp_pop   = rsp_valid && rsp_ready;

    // Next-state and next app-side register values; command and data sides retire independently.
    always_comb begin
        state_d    = state_q;
        app_en_d   = app_en;
        app_cmd_d  = app_cmd;
        app_addr_d = app_addr;
        wren_d     = app_wdf_wren;
        wdata_d    = app_wdf_data;
        wmask_d    = app_wdf_mask;
        unique case (state_q)
            CALIB: begin
                if (init_calib_complete) state_d = IDLE;
            end
            IDLE: begin
                if (!init_calib_complete) begin
                    state_d = CALIB;
                end else if (req_fire) begin
                    state_d    = ISSUE;
                    app_en_d   = 1'b1;
                    app_cmd_d  = req_write ? APP_CMD_WRITE : APP_CMD_READ;
                    app_addr_d = req_addr;
                    wren_d     = req_write;
                    if (req_write) begin
                        wdata_d = req_data;
                        wmask_d = req_mask;
                    end
                end
            end
            ISSUE: begin
                if (app_rdy)     app_en_d = 1'b0;
                if (app_wdf_rdy) wren_d   = 1'b0;
                if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy)) state_d = IDLE;
            end
            default: state_d = CALIB;
        endcase
    end

    // Credit count: one per accepted read, returned when its response is consumed.
    always_comb begin
        credits_d = credits_q + CNT_WIDTH'(rd_fire) - CNT_WIDTH'(rsp_pop);
    end

    // State, app-side outputs and credits.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= CALIB;
            app_en       <= 1'b0;
            app_cmd      <= '0;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            credits_q    <= '0;
        end else begin
            state_q      <= state_d;
            app_en       <= app_en_d;
            app_cmd      <= app_cmd_d;
            app_addr     <= app_addr_d;
            app_wdf_wren <= wren_d;
            app_wdf_data <= wdata_d;
            app_wdf_mask <= wmask_d;
            credits_q    <= credits_d;
        end
    end

    assign app_wdf_end       = app_wdf_wren;
    assign reads_outstanding = credits_q;
    assign rsp_valid         = !rsp_empty;

    ddr3_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (app_rd_data_valid),
        .wr_data (app_rd_data),
        .rd_en   (rsp_pop),
        .rd_data (rsp_data),
        .full    (rsp_full),
        .empty   (rsp_empty)
    );

    // A return beat into a full FIFO with no pop means the credit accounting was broken.
    overflow_a: assert property (@(posedge CLK) disable iff (!RST_N)
                                 !(app_rd_data_valid && rsp_full && !rsp_pop))
        else $fatal(1, "ddr3_app_requester: response fifo overflow");

endmodule

// File: tb/tb_ddr3_app_requester.sv
// Directed bench for ddr3_app_requester; inputs change and outputs are sampled on the falling edge.
module tb_ddr3_app_requester;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 512;
    localparam int unsigned MW = DW / 8;

    logic           CLK;
    logic           RST_N;
    logic           init_calib_complete;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_data;
    logic [MW-1:0]  req_mask;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [DW-1:0]  rsp_data;
    logic           app_en;
    logic [2:0]     app_cmd;
    logic [AW-1:0]  app_addr;
    logic           app_rdy;
    logic           app_wdf_wren;
    logic           app_wdf_end;
    logic [DW-1:0]  app_wdf_data;
    logic [MW-1:0]  app_wdf_mask;
    logic           app_wdf_rdy;
    logic [DW-1:0]  app_rd_data;
    logic           app_rd_data_valid;
    logic [3:0]     reads_outstanding;

    int tests_run;
    int tests_failed;

    ddr3_app_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .init_calib_complete(init_calib_complete),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .reads_outstanding(reads_outstanding)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rd_word(input int i);
        return DW'(32'hC0DE_0000 + 32'(i));
    endfunction

    task automatic test_reset();
        RST_N = 1'b0; init_calib_complete = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_data = '0; req_mask = '0; rsp_ready = 1'b0; app_rdy = 1'b0;
        app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0;
        #23;
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
        tests_run++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0) begin tests_failed++; $display("FAIL rst_app_en_wren: got %b%b%b want 000", app_en, app_wdf_wren, app_wdf_end); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        tests_run++; if (app_cmd !== 3'd0 || app_addr !== '0) begin tests_failed++; $display("FAIL rst_cmd_addr: got %0h/%0h want 0/0", app_cmd, app_addr); end
        tests_run++; if (app_wdf_data !== '0 || app_wdf_mask !== '0) begin tests_failed++; $display("FAIL rst_wdf: data/mask not zero"); end
        tests_run++; if (reads_outstanding !== 4'd0) begin tests_failed++; $display("FAIL rst_credits: got %0d want 0", reads_outstanding); end
    endtask

    task automatic test_calib_gating();
        @(negedge CLK);
        RST_N = 1'b1; req_valid = 1'b1; req_write = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            tests_run++; if (req_ready !== 1'b0 || app_en !== 1'b0) begin tests_failed++; $display("FAIL calib_hold[%0d]: ready/en got %b/%b want 0/0", c, req_ready, app_en); end
        end
        init_calib_complete = 1'b1;
        @(negedge CLK);
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL calib_release: req_ready got %b want 1", req_ready); end
        req_valid = 1'b0;
    endtask

    task automatic test_write_skew();
        logic [DW-1:0] wd;
        wd = {MW{8'hA5}};
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(32'h100); req_data = wd; req_mask = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        #1;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL wr_accept: req_ready got %b want 1", req_ready); end
        @(negedge CLK);
        req_valid = 1'b0; req_data = '0;
        tests_run++; if (app_en !== 1'b1 || app_cmd !== 3'b000 || app_addr !== AW'(32'h100)) begin tests_failed++; $display("FAIL wr_cmd: en/cmd/addr got %b/%0h/%0h want 1/0/100", app_en, app_cmd, app_addr); end
        tests_run++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_wdf_data !== wd || app_wdf_mask !== '0) begin tests_failed++; $display("FAIL wr_data_first: wren/end got %b/%b data %0h", app_wdf_wren, app_wdf_end, app_wdf_data); end
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL wr_busy_ready: got %b want 0", req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            tests_run++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_wdf_data !== wd) begin tests_failed++; $display("FAIL wr_hold[%0d]: en/wren/end got %b/%b/%b want 0/1/1", c, app_en, app_wdf_wren, app_wdf_end); end
        end
        app_wdf_rdy = 1'b1;
        @(negedge CLK);
        app_wdf_rdy = 1'b0;
        tests_run++; if (app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0) begin tests_failed++; $display("FAIL wr_drop: wren/end got %b/%b want 0/0", app_wdf_wren, app_wdf_end); end
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL wr_idle: req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_read_roundtrip();
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(32'h40); app_rdy = 1'b1;
        #1;
        tests_run++; if (req_ready !== 1'b1 || reads_outstanding !== 4'd0) begin tests_failed++; $display("FAIL rd_accept: ready/outst got %b/%0d want 1/0", req_ready, reads_outstanding); end
        @(negedge CLK);
        req_valid = 1'b0;
        tests_run++; if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== AW'(32'h40) || app_wdf_wren !== 1'b0) begin tests_failed++; $display("FAIL rd_cmd: en/cmd/addr/wren got %b/%0h/%0h/%b want 1/1/40/0", app_en, app_cmd, app_addr, app_wdf_wren); end
        tests_run++; if (reads_outstanding !== 4'd1) begin tests_failed++; $display("FAIL rd_credit_take: got %0d want 1", reads_outstanding); end
        @(negedge CLK);
        tests_run++; if (app_en !== 1'b0 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_wait: en/rsp_valid got %b/%b want 0/0", app_en, rsp_valid); end
        @(negedge CLK);
        app_rd_data_valid = 1'b1; app_rd_data = DW'(32'h1234);
        @(negedge CLK);
        app_rd_data_valid = 1'b0; app_rd_data = '0;
        tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== DW'(32'h1234)) begin tests_failed++; $display("FAIL rd_rsp: valid/data got %b/%0h want 1/1234", rsp_valid, rsp_data); end
        tests_run++; if (reads_outstanding !== 4'd1) begin tests_failed++; $display("FAIL rd_credit_hold: got %0d want 1", reads_outstanding); end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        tests_run++; if (rsp_valid !== 1'b0 || reads_outstanding !== 4'd0) begin tests_failed++; $display("FAIL rd_pop: valid/outst got %b/%0d want 0/0", rsp_valid, reads_outstanding); end
    endtask

    task automatic test_credit_limit();
        rsp_ready = 1'b0; app_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(32'h200 + 32'(i));
            #1;
            tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL cl_accept[%0d]: req_ready got %b want 1", i, req_ready); end
            @(negedge CLK);
            req_valid = 1'b0;
            @(negedge CLK);
            tests_run++; if (reads_outstanding !== 4'(i + 1)) begin tests_failed++; $display("FAIL cl_outst[%0d]: got %0d want %0d", i, reads_outstanding, i + 1); end
        end
        for (int i = 0; i < 8; i++) begin
            app_rd_data_valid = 1'b1; app_rd_data = rd_word(i);
            @(negedge CLK);
        end
        app_rd_data_valid = 1'b0; app_rd_data = '0;
        tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== rd_word(0) || reads_outstanding !== 4'd8) begin tests_failed++; $display("FAIL cl_full: valid/outst got %b/%0d data %0h", rsp_valid, reads_outstanding, rsp_data); end
        req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(32'h208);
        #1;
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL cl_block: req_ready got %b want 0", req_ready); end
        @(negedge CLK);
        tests_run++; if (app_en !== 1'b0 || req_ready !== 1'b0) begin tests_failed++; $display("FAIL cl_block_hold: en/ready got %b/%b want 0/0", app_en, req_ready); end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        tests_run++; if (reads_outstanding !== 4'd7 || rsp_data !== rd_word(1)) begin tests_failed++; $display("FAIL cl_pop: outst got %0d want 7 data %0h", reads_outstanding, rsp_data); end
        #1;
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL cl_unblock: req_ready got %b want 1", req_ready); end
        @(negedge CLK);
        req_valid = 1'b0;
        tests_run++; if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== AW'(32'h208) || reads_outstanding !== 4'd8) begin tests_failed++; $display("FAIL cl_ninth: en/cmd/addr/outst got %b/%0h/%0h/%0d", app_en, app_cmd, app_addr, reads_outstanding); end
        @(negedge CLK);
    endtask

    task automatic test_simultaneous();
        app_rd_data_valid = 1'b1; app_rd_data = rd_word(8);
        @(negedge CLK);
        tests_run++; if (reads_outstanding !== 4'd8 || rsp_data !== rd_word(1)) begin tests_failed++; $display("FAIL sim_fill: outst got %0d want 8 data %0h", reads_outstanding, rsp_data); end
        rsp_ready = 1'b1; app_rd_data = DW'(32'hEE);
        @(negedge CLK);
        app_rd_data_valid = 1'b0; app_rd_data = '0;
        tests_run++; if (reads_outstanding !== 4'd7 || rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL sim_pushpop: outst/valid got %0d/%b want 7/1", reads_outstanding, rsp_valid); end
        for (int k = 0; k < 7; k++) begin
            tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== rd_word(2 + k)) begin tests_failed++; $display("FAIL sim_order[%0d]: got %0h want %0h", k, rsp_data, rd_word(2 + k)); end
            @(negedge CLK);
        end
        rsp_ready = 1'b0;
        tests_run++; if (rsp_valid !== 1'b1 || rsp_data !== DW'(32'hEE) || reads_outstanding !== 4'd0) begin tests_failed++; $display("FAIL sim_tail: valid/outst got %b/%0d data %0h", rsp_valid, reads_outstanding, rsp_data); end
    endtask

    task automatic test_reset_mid_issue();
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(32'h300); req_data = {MW{8'h3C}};
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        @(negedge CLK);
        req_valid = 1'b0;
        tests_run++; if (app_en !== 1'b1 || app_wdf_wren !== 1'b1 || rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL rmi_pre: en/wren/rsp got %b/%b/%b want 1/1/1", app_en, app_wdf_wren, rsp_valid); end
        #2;
        RST_N = 1'b0;
        #1;
        tests_run++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rmi_async: en/wren/rsp got %b/%b/%b want 0/0/0", app_en, app_wdf_wren, rsp_valid); end
        tests_run++; if (reads_outstanding !== 4'd0 || app_addr !== '0) begin tests_failed++; $display("FAIL rmi_clear: outst/addr got %0d/%0h want 0/0", reads_outstanding, app_addr); end
        @(negedge CLK);
        @(negedge CLK);
        req_valid = 1'b1; req_write = 1'b1;
        RST_N = 1'b1;
        #1;
        tests_run++; if (req_ready !== 1'b0 || app_en !== 1'b0) begin tests_failed++; $display("FAIL rmi_calib: ready/en got %b/%b want 0/0", req_ready, app_en); end
        @(negedge CLK);
        tests_run++; if (req_ready !== 1'b1 || app_en !== 1'b0) begin tests_failed++; $display("FAIL rmi_idle: ready/en got %b/%b want 1/0", req_ready, app_en); end
        req_valid = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_calib_gating();
        test_write_skew();
        test_read_roundtrip();
        test_credit_limit();
        test_simultaneous();
        test_reset_mid_issue();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
